// File: rtl/pmu_cb_pkg.sv
// Shared types and defaults for the PMU event-counter bank.
// Snapshot support is enabled with PMU_COUNTER_SNAPSHOT_EN.
package pmu_cb_pkg;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } cnt_mode_e;

    localparam int unsigned PMU_REG_WIDTH  = 32;
    localparam int unsigned PMU_N_COUNTERS = 24;
    localparam int unsigned PMU_N_SOC_EV   = 128;

    // Never returns 0 so one-entry configurations keep a legal index width.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pmu_cb_crossbar.sv
// Registered N-to-M event crossbar with synchronous clear.
// Each output registers the event line chosen by its selector field.
module pmu_cb_crossbar
    import pmu_cb_pkg::*;
#(
    parameter int unsigned N_IN  = PMU_N_SOC_EV,
    parameter int unsigned N_OUT = PMU_N_COUNTERS,
    parameter int unsigned SEL_W = sel_width(N_IN)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clr_i,
    input  logic [N_IN-1:0]        events_i,
    input  logic [N_OUT*SEL_W-1:0] sel_i,
    output logic [N_OUT-1:0]       cbo_o
);

    logic [N_OUT-1:0] cbo_d;
    logic [N_OUT-1:0] cbo_q;

    always_comb begin
        cbo_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            cbo_d[k] = events_i[sel_i[k*SEL_W +: SEL_W]];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cbo_q <= '0;
        end else if (clr_i) begin
            cbo_q <= '0;
        end else begin
            cbo_q <= cbo_d;
        end
    end

    assign cbo_o = cbo_q;

endmodule

// File: rtl/pmu_counter_bank.sv
// PMU counter bank: crossbar-routed events, level/edge counting, sticky overflow.
// Define PMU_COUNTER_SNAPSHOT_EN to build the atomic snapshot copy.
module pmu_counter_bank
    import pmu_cb_pkg::*;
#(
    parameter int unsigned REG_WIDTH  = PMU_REG_WIDTH,
    parameter int unsigned N_COUNTERS = PMU_N_COUNTERS,
    parameter int unsigned N_SOC_EV   = PMU_N_SOC_EV
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            en_i,
    input  logic                            softrst_i,
    input  logic [N_SOC_EV-1:0]             events_i,
    input  logic [N_COUNTERS*sel_width(N_SOC_EV)-1:0] sel_i,
    input  logic [N_COUNTERS-1:0]           mode_i,
    input  logic [N_COUNTERS-1:0]           cnt_en_i,
    input  logic                            we_i,
    input  logic [sel_width(N_COUNTERS)-1:0] wr_idx_i,
    input  logic [REG_WIDTH-1:0]            wr_data_i,
    input  logic [N_COUNTERS-1:0]           ovf_clr_i,
    input  logic                            snap_req_i,
    output logic [N_COUNTERS*REG_WIDTH-1:0] counters_o,
    output logic [N_COUNTERS-1:0]           ovf_o,
    output logic                            intr_overflow_o,
    output logic [N_COUNTERS*REG_WIDTH-1:0] snap_o,
    output logic                            snap_valid_o
);

    localparam int unsigned SEL_W = sel_width(N_SOC_EV);
    localparam int unsigned IDX_W = sel_width(N_COUNTERS);

    logic [N_COUNTERS-1:0] cbo_q;

    pmu_cb_crossbar #(
        .N_IN  (N_SOC_EV),
        .N_OUT (N_COUNTERS),
        .SEL_W (SEL_W)
    ) u_xbar (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (softrst_i),
        .events_i (events_i),
        .sel_i    (sel_i),
        .cbo_o    (cbo_q)
    );

    for (genvar k = 0; k < N_COUNTERS; k++) begin : g_cnt
        logic [REG_WIDTH-1:0] cnt_q;
        logic [REG_WIDTH-1:0] cnt_d;
        logic                 ovf_q;
        logic                 ovf_d;
        logic                 prev_q;
        logic                 inc;
        logic                 wr_hit;
        logic                 wrap;
        cnt_mode_e            mode;

        assign mode   = cnt_mode_e'(mode_i[k]);
        // Indices at or above N_COUNTERS can never match a genvar.
        assign wr_hit = we_i && (wr_idx_i == IDX_W'(k));

        always_comb begin
            inc = en_i & cnt_en_i[k] & cbo_q[k];
            if (mode == MODE_EDGE) begin
                inc = inc & ~prev_q;
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            wrap  = 1'b0;
            if (softrst_i) begin
                cnt_d = '0;
            end else if (wr_hit) begin
                cnt_d = wr_data_i;
            end else if (inc) begin
                cnt_d = cnt_q + REG_WIDTH'(1);
                wrap  = &cnt_q;
            end
            // A wrap in the same cycle as a clear keeps the flag set.
            ovf_d = softrst_i ? 1'b0 : ((ovf_q & ~ovf_clr_i[k]) | wrap);
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                ovf_q  <= ovf_d;
                prev_q <= softrst_i ? 1'b0 : cbo_q[k];
            end
        end

        assign counters_o[k*REG_WIDTH +: REG_WIDTH] = cnt_q;
        assign ovf_o[k] = ovf_q;
    end

    assign intr_overflow_o = |ovf_o;

`ifdef PMU_COUNTER_SNAPSHOT_EN
    logic [N_COUNTERS*REG_WIDTH-1:0] snap_q;
    logic                            snap_valid_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else if (softrst_i) begin
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            snap_valid_q <= snap_req_i;
            if (snap_req_i) begin
                snap_q <= counters_o;
            end
        end
    end

    assign snap_o       = snap_q;
    assign snap_valid_o = snap_valid_q;
`else
    logic unused_snap_req;

    assign unused_snap_req = snap_req_i;
    assign snap_o          = '0;
    assign snap_valid_o    = 1'b0;
`endif

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed-vector bench for pmu_counter_bank (default parameters).
// Snapshot checks follow PMU_COUNTER_SNAPSHOT_EN.
module tb_pmu_counter_bank;

    localparam int RW = 32;
    localparam int NC = 24;
    localparam int NE = 128;
    localparam int SW = 7;
    localparam int IW = 5;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic             softrst;
    logic [NE-1:0]    events;
    logic [NC*SW-1:0] sel;
    logic [NC-1:0]    mode;
    logic [NC-1:0]    cnt_en;
    logic             we;
    logic [IW-1:0]    wr_idx;
    logic [RW-1:0]    wr_data;
    logic [NC-1:0]    ovf_clr;
    logic             snap_req;
    logic [NC*RW-1:0] counters;
    logic [NC-1:0]    ovf;
    logic             intr;
    logic [NC*RW-1:0] snap;
    logic             snap_valid;

    int n_vec  = 0;
    int n_miss = 0;

    logic [NC*RW-1:0] exp_snap;

    always #5 clk = ~clk;

    pmu_counter_bank dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .en_i            (en),
        .softrst_i       (softrst),
        .events_i        (events),
        .sel_i           (sel),
        .mode_i          (mode),
        .cnt_en_i        (cnt_en),
        .we_i            (we),
        .wr_idx_i        (wr_idx),
        .wr_data_i       (wr_data),
        .ovf_clr_i       (ovf_clr),
        .snap_req_i      (snap_req),
        .counters_o      (counters),
        .ovf_o           (ovf),
        .intr_overflow_o (intr),
        .snap_o          (snap),
        .snap_valid_o    (snap_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic soft_reset();
        softrst = 1'b1;
        tick(1);
        softrst = 1'b0;
    endtask

    task automatic set_sel(input int k, input int v);
        sel[k*SW +: SW] = SW'(v);
    endtask

    function automatic logic [RW-1:0] cnt(input int k);
        return counters[k*RW +: RW];
    endfunction

    function automatic int nz_except(input int k);
        int n = 0;
        for (int i = 0; i < NC; i++) begin
            if (i != k && counters[i*RW +: RW] != '0) n++;
        end
        return n;
    endfunction

    initial begin
        rstn     = 1'b0;
        en       = 1'b0;
        softrst  = 1'b0;
        events   = '0;
        sel      = '0;
        mode     = '0;
        cnt_en   = '0;
        we       = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        ovf_clr  = '0;
        snap_req = 1'b0;
        tick(3);
        check("rst_counters", 64'(counters != '0), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_intr", 64'(intr), 64'd0);
        check("rst_snap", 64'(snap != '0), 64'd0);
        check("rst_snap_valid", 64'(snap_valid), 64'd0);
        rstn   = 1'b1;
        en     = 1'b1;
        cnt_en = '1;
        tick(1);

        // Level mode, 10 high cycles
        set_sel(0, 5);
        tick(1);
        events[5] = 1'b1;
        tick(10);
        events[5] = 1'b0;
        tick(3);
        check("level_cnt0", 64'(cnt(0)), 64'd10);
        check("level_cnt1", 64'(cnt(1)), 64'd0);

        // Edge mode, 5 pulses
        soft_reset();
        check("softrst_cnt0", 64'(cnt(0)), 64'd0);
        set_sel(3, 100);
        mode[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            events[100] = 1'b1;
            tick(1);
            events[100] = 1'b0;
            tick(1);
        end
        tick(3);
        check("edge_toggle", 64'(cnt(3)), 64'd5);

        soft_reset();
        mode[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            events[100] = 1'b1;
            tick(1);
            events[100] = 1'b0;
            tick(1);
        end
        tick(3);
        check("level_toggle", 64'(cnt(3)), 64'd5);

        soft_reset();
        mode[3] = 1'b1;
        events[100] = 1'b1;
        tick(8);
        events[100] = 1'b0;
        tick(3);
        check("edge_held", 64'(cnt(3)), 64'd1);
        mode[3] = 1'b0;

        // Global and per-counter enables
        soft_reset();
        set_sel(4, 30);
        events[30] = 1'b1;
        en = 1'b0;
        tick(4);
        check("global_en_off", 64'(cnt(4)), 64'd0);
        en = 1'b1;
        cnt_en[4] = 1'b0;
        tick(4);
        check("cnt_en_off", 64'(cnt(4)), 64'd0);
        cnt_en[4] = 1'b1;
        events[30] = 1'b0;

        // Preload, wrap and overflow
        soft_reset();
        set_sel(2, 10);
        we      = 1'b1;
        wr_idx  = 5'd2;
        wr_data = 32'hFFFF_FFFE;
        tick(1);
        we = 1'b0;
        check("preload", 64'(cnt(2)), 64'hFFFF_FFFE);
        events[10] = 1'b1;
        tick(3);
        events[10] = 1'b0;
        tick(3);
        check("wrap_cnt", 64'(cnt(2)), 64'd1);
        check("wrap_ovf", 64'(ovf[2]), 64'd1);
        check("wrap_intr", 64'(intr), 64'd1);
        ovf_clr[2] = 1'b1;
        tick(1);
        ovf_clr[2] = 1'b0;
        check("ovf_clr", 64'(ovf[2]), 64'd0);
        check("ovf_clr_intr", 64'(intr), 64'd0);

        // Clear coinciding with a wrap keeps the flag
        we      = 1'b1;
        wr_idx  = 5'd2;
        wr_data = 32'hFFFF_FFFF;
        tick(1);
        we = 1'b0;
        events[10] = 1'b1;
        tick(1);
        events[10] = 1'b0;
        ovf_clr[2] = 1'b1;
        tick(1);
        ovf_clr[2] = 1'b0;
        check("clr_vs_wrap_cnt", 64'(cnt(2)), 64'd0);
        check("clr_vs_wrap_ovf", 64'(ovf[2]), 64'd1);
        check("clr_vs_wrap_intr", 64'(intr), 64'd1);

        // Out-of-range preload index
        soft_reset();
        check("softrst_ovf", 64'(ovf), 64'd0);
        we      = 1'b1;
        wr_idx  = 5'd24;
        wr_data = 32'h0000_0ABC;
        tick(1);
        we = 1'b0;
        check("wr_idx_oob", 64'(nz_except(-1)), 64'd0);

        // Preload beats increment; softrst beats preload
        set_sel(7, 20);
        events[20] = 1'b1;
        tick(4);
        we      = 1'b1;
        wr_idx  = 5'd7;
        wr_data = 32'h10;
        tick(1);
        we = 1'b0;
        check("we_over_inc", 64'(cnt(7)), 64'h10);
        tick(1);
        check("inc_after_we", 64'(cnt(7)), 64'h11);
        softrst = 1'b1;
        we      = 1'b1;
        wr_data = 32'h55;
        tick(1);
        softrst = 1'b0;
        we      = 1'b0;
        check("softrst_over_we", 64'(cnt(7)), 64'd0);

        // Async reset mid-operation, then pipeline refill
        tick(3);
        #2 rstn = 1'b0;
        #1 check("async_rst_cnt", 64'(cnt(7)), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick(1);
        check("refill_t1", 64'(cnt(7)), 64'd0);
        tick(1);
        check("refill_t2", 64'(cnt(7)), 64'd1);

        // Snapshot
        tick(2);
        exp_snap = counters;
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
`ifdef PMU_COUNTER_SNAPSHOT_EN
        check("snap_valid_hi", 64'(snap_valid), 64'd1);
        check("snap_match", 64'(snap == exp_snap), 64'd1);
        check("snap_cnt7", 64'(snap[7*RW +: RW]), 64'd3);
        tick(1);
        check("snap_valid_lo", 64'(snap_valid), 64'd0);
        check("snap_hold", 64'(snap == exp_snap), 64'd1);
`else
        check("snap_zero", 64'(snap != '0), 64'd0);
        check("snap_valid_zero", 64'(snap_valid), 64'd0);
        tick(1);
        check("snap_valid_zero2", 64'(snap_valid), 64'd0);
`endif
        events[20] = 1'b0;

        // Crossbar sweep
        mode = '0;
        for (int in = 0; in < NE; in++) begin
            for (int out = 0; out < NC; out++) begin
                for (int k = 0; k < NC; k++) set_sel(k, in ^ 1);
                set_sel(out, in);
                soft_reset();
                events[in] = 1'b1;
                tick(2);
                events = '0;
                tick(2);
                check($sformatf("xbar_hit_%0d_%0d", in, out),
                      64'(cnt(out)), 64'd2);
                check($sformatf("xbar_iso_%0d_%0d", in, out),
                      64'(nz_except(out)), 64'd0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
